// File: rtl/status_vector_queue_if.sv
// Request/status bundle of the in-order status queue.
// The master issues push/pull/set requests; the slave (the queue) reports its state.
interface status_vector_queue_if #(
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             push_i;
    logic             value_i;
    logic             pull_i;
    logic             set_i;
    logic [IDX_W-1:0] set_idx_i;
    logic [DEPTH-1:0] valid_o;
    logic [DEPTH-1:0] status_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;
    logic             head_done_o;
    logic             err_o;

    modport master (
        output push_i, value_i, pull_i, set_i, set_idx_i,
        input  valid_o, status_o, count_o, full_o, empty_o, head_done_o, err_o
    );

    modport slave (
        input  push_i, value_i, pull_i, set_i, set_idx_i,
        output valid_o, status_o, count_o, full_o, empty_o, head_done_o, err_o
    );
endinterface

// File: rtl/status_vector_queue.sv
// In-order queue of single-bit status entries; head is always entry [0].
// Entries are appended at index count, shift toward [0] on pull, and can be set sticky by index.
module status_vector_queue #(
    parameter int DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    status_vector_queue_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_r;
    logic [DEPTH-1:0] status_r;
    logic             err_r;

    logic             pull_acc_s;
    logic             push_acc_s;
    logic [CNT_W-1:0] target_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [DEPTH-1:0] hit_s;
    logic [DEPTH:0]   ext_s;
    logic [DEPTH-1:0] status_nxt_s;
    logic             err_nxt_s;

    // A set only lands on an entry that is already valid before this cycle's update.
    function automatic logic set_hit(input logic set, input logic [IDX_W-1:0] idx,
                                     input int j, input logic [CNT_W-1:0] cnt);
        return set && (int'(idx) == j) && (j < int'(cnt));
    endfunction

    // Acceptance, next occupancy and next per-entry status.
    always_comb begin
        pull_acc_s   = bus.pull_i && (count_r != {CNT_W{1'b0}});
        push_acc_s   = bus.push_i && ((count_r != FULL_CNT) || pull_acc_s);
        target_s     = count_r - CNT_W'(pull_acc_s);
        count_nxt_s  = count_r + CNT_W'(push_acc_s) - CNT_W'(pull_acc_s);
        err_nxt_s    = (bus.push_i && !push_acc_s) || (bus.pull_i && !pull_acc_s);
        hit_s        = {DEPTH{1'b0}};
        status_nxt_s = {DEPTH{1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
            hit_s[j] = set_hit(bus.set_i, bus.set_idx_i, j, count_r);
        end
        // Extra top bit supplies the zero shifted into the last entry on a pull.
        ext_s = {1'b0, status_r | hit_s};
        for (int i = 0; i < DEPTH; i++) begin
            if (push_acc_s && (int'(target_s) == i)) begin
                status_nxt_s[i] = bus.value_i;
            end else if (pull_acc_s) begin
                status_nxt_s[i] = ext_s[i+1];
            end else begin
                status_nxt_s[i] = ext_s[i];
            end
            status_nxt_s[i] = status_nxt_s[i] && (i < int'(count_nxt_s));
        end
    end

    // State registers; cleared immediately on reset assertion.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count_r  <= {CNT_W{1'b0}};
            status_r <= {DEPTH{1'b0}};
            err_r    <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            status_r <= status_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.valid_o = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            bus.valid_o[i] = (i < int'(count_r));
        end
        bus.status_o    = status_r;
        bus.count_o     = count_r;
        bus.full_o      = (count_r == FULL_CNT);
        bus.empty_o     = (count_r == {CNT_W{1'b0}});
        bus.head_done_o = (count_r != {CNT_W{1'b0}}) && status_r[0];
        bus.err_o       = err_r;
    end
endmodule

// File: tb/tb_status_vector_queue.sv
// Scoreboard bench for status_vector_queue (DEPTH=4): directed plan then random traffic
// against a queue-based reference model.
module tb_status_vector_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] status;
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       hd;
        logic       err;
    } obs_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bit   mq[$];
    bit   merr;
    obs_t exp_q[$];
    obs_t mon_e;
    obs_t mon_g;

    status_vector_queue_if #(.DEPTH(DEPTH)) bus ();

    status_vector_queue #(.DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o = '0;
        for (int i = 0; i < mq.size(); i++) begin
            o.valid[i]  = 1'b1;
            o.status[i] = mq[i];
        end
        o.count = 3'(mq.size());
        o.full  = (mq.size() == DEPTH);
        o.empty = (mq.size() == 0);
        o.hd    = (mq.size() > 0) && mq[0];
        o.err   = merr;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid  = bus.valid_o;
        o.status = bus.status_o;
        o.count  = bus.count_o;
        o.full   = bus.full_o;
        o.empty  = bus.empty_o;
        o.hd     = bus.head_done_o;
        o.err    = bus.err_o;
        return o;
    endfunction

    // Apply one cycle of requests; the model result is queued once the edge has happened.
    task automatic step(input bit p, input bit v, input bit q, input bit s, input int idx);
        int  c;
        bit  pa;
        bit  ua;
        bus.push_i    = p;
        bus.value_i   = v;
        bus.pull_i    = q;
        bus.set_i     = s;
        bus.set_idx_i = 2'(idx);
        c  = mq.size();
        ua = q && (c != 0);
        pa = p && ((c != DEPTH) || ua);
        merr = (p && !pa) || (q && !ua);
        if (s && idx < c) mq[idx] = 1'b1;
        if (ua) void'(mq.pop_front());
        if (pa) mq.push_back(v);
        @(posedge clk);
        exp_q.push_back(model_obs());
        #1;
    endtask

    // Monitor: compare every presented state against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = dut_obs();
            tests++;
            if (mon_g !== mon_e) begin
                fails++;
                $display("FAIL state t=%0t: got valid=%b status=%b count=%0d full=%b empty=%b hd=%b err=%b, need valid=%b status=%b count=%0d full=%b empty=%b hd=%b err=%b",
                         $time, mon_g.valid, mon_g.status, mon_g.count, mon_g.full, mon_g.empty, mon_g.hd, mon_g.err,
                         mon_e.valid, mon_e.status, mon_e.count, mon_e.full, mon_e.empty, mon_e.hd, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t g;
        obs_t r;
        tests = 0;
        fails = 0;
        merr  = 1'b0;
        rst_n = 1'b0;
        bus.push_i = 1'b0; bus.value_i = 1'b0; bus.pull_i = 1'b0;
        bus.set_i = 1'b0; bus.set_idx_i = 2'd0;
        #22;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        // Fill with 1,0,0,1
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // Overflow, then set idx 2
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 2);
        // Push+pull on full
        step(1, 0, 1, 0, 0);
        // Pull with set on idx 0 (dropped), then on idx 3 (out of range)
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 3);
        // Drain and empty corner
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        // Asynchronous reset in the middle of the burst
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        mq.delete();
        merr = 1'b0;
        r = model_obs();
        g = dut_obs();
        tests++;
        if (g !== r) begin
            fails++;
            $display("FAIL async_reset: got %b, need %b", g, r);
        end
        bus.push_i = 1'b0; bus.pull_i = 1'b0; bus.set_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
                 int'($urandom_range(0, DEPTH - 1)));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
